counter_mod_n: RTL and testbench

//   Parametrised up/down modulo counter; successor to the fixed 32-bit free-running counter.

---
 rtl/counter_mod_n_pkg.sv | 15 +
 rtl/adder_n.sv | 23 ++
 rtl/counter_mod_n.sv | 109 ++++++++++
 tb/tb_counter_mod_n.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_mod_n_pkg.sv
// Shared constants and types for the modulo counter and related counter/timer blocks.
package counter_mod_n_pkg;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   // Per-cycle operation selected by the reset/load/en priority decode.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_UP   = 2'd2,
      OP_DOWN = 2'd3
   } op_e;

endpackage

// File: rtl/adder_n.sv
// Parametrised ripple-carry adder used as the shared up/down step datapath.
module adder_n #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] S,
   output logic         Cout
);

   always_comb begin
      logic carry;
      carry = Cin;
      S     = '0;
      for (int i = 0; i < int'(N); i++) begin
         S[i]  = A[i] ^ B[i] ^ carry;
         carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
      end
      Cout = carry;
   end

endmodule

// File: rtl/counter_mod_n.sv
// Up/down modulo-(MAX_VAL+1) counter with load, enable, wrap or saturate,
// registered overflow/underflow pulses and combinational limit decodes.
module counter_mod_n
   import counter_mod_n_pkg::*;
#(
   parameter int unsigned    WIDTH    = 32,
   parameter logic [WIDTH:0] MAX_VAL  = {1'b0, {WIDTH{1'b1}}},
   parameter logic [WIDTH:0] STEP     = {{WIDTH{1'b0}}, 1'b1},
   parameter bit             SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_zero
);

   localparam int unsigned    W1      = WIDTH + 1;
   localparam logic [WIDTH:0] MOD_VAL = MAX_VAL + W1'(1);

   if (WIDTH < 2) begin : g_bad_width
      $error("counter_mod_n: WIDTH must be at least 2");
   end
   if (STEP == '0) begin : g_bad_step_zero
      $error("counter_mod_n: STEP must be non-zero");
   end
   if (STEP > MAX_VAL) begin : g_bad_step_big
      $error("counter_mod_n: STEP must not exceed MAX_VAL");
   end
   if (MAX_VAL[WIDTH]) begin : g_bad_max
      $error("counter_mod_n: MAX_VAL must fit in WIDTH bits");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH:0]   add_b, sum;
   logic             add_cin, add_cout;
   op_e              op;

   // Down-count is q + ~STEP + 1; a missing carry-out is the borrow.
   assign add_b   = up ? STEP : ~STEP;
   assign add_cin = ~up;

   adder_n #(.N(W1)) u_adder (
      .A    ({1'b0, q_q}),
      .B    (add_b),
      .Cin  (add_cin),
      .S    (sum),
      .Cout (add_cout)
   );

   always_comb begin
      op    = OP_HOLD;
      q_d   = q_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         op = up ? OP_UP : OP_DOWN;
      end
      case (op)
         OP_LOAD: q_d = ({1'b0, load_val} > MAX_VAL) ? MAX_VAL[WIDTH-1:0] : load_val;
         OP_UP: begin
            if (sum > MAX_VAL) begin
               ovf_d = 1'b1;
               q_d   = (SATURATE == MODE_SAT) ? MAX_VAL[WIDTH-1:0] : WIDTH'(sum - MOD_VAL);
            end else begin
               q_d = sum[WIDTH-1:0];
            end
         end
         OP_DOWN: begin
            if (!add_cout) begin
               unf_d = 1'b1;
               q_d   = (SATURATE == MODE_SAT) ? '0 : WIDTH'(sum + MOD_VAL);
            end else begin
               q_d = sum[WIDTH-1:0];
            end
         end
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q   <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign q       = q_q;
   assign ovf     = ovf_q;
   assign unf     = unf_q;
   assign at_max  = (q_q == MAX_VAL[WIDTH-1:0]);
   assign at_zero = (q_q == '0);

endmodule

// File: tb/tb_counter_mod_n.sv
// Self-checking bench: three counter configurations against an arithmetic reference model.
module tb_counter_mod_n;

   typedef struct {
      longint unsigned q;
      bit              ovf;
      bit              unf;
   } st_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance a: 4-bit, 0..9, step 1, wrap
   logic       rst_a, en_a, up_a, ld_a;
   logic [3:0] lv_a, q_a;
   logic       ovf_a, unf_a, amax_a, azero_a;
   // Instance b: 4-bit, 0..9, step 3, saturate
   logic       rst_b, en_b, up_b, ld_b;
   logic [3:0] lv_b, q_b;
   logic       ovf_b, unf_b, amax_b, azero_b;
   // Instance c: defaults, 32-bit free-running
   logic        rst_c, en_c, up_c, ld_c;
   logic [31:0] lv_c, q_c;
   logic        ovf_c, unf_c, amax_c, azero_c;

   st_t sa, sb, sc;

   counter_mod_n #(.WIDTH(4), .MAX_VAL(5'd9), .STEP(5'd1), .SATURATE(1'b0)) u_dut_a (
      .clk(clk), .reset(rst_a), .en(en_a), .up(up_a), .load(ld_a), .load_val(lv_a),
      .q(q_a), .ovf(ovf_a), .unf(unf_a), .at_max(amax_a), .at_zero(azero_a));

   counter_mod_n #(.WIDTH(4), .MAX_VAL(5'd9), .STEP(5'd3), .SATURATE(1'b1)) u_dut_b (
      .clk(clk), .reset(rst_b), .en(en_b), .up(up_b), .load(ld_b), .load_val(lv_b),
      .q(q_b), .ovf(ovf_b), .unf(unf_b), .at_max(amax_b), .at_zero(azero_b));

   counter_mod_n u_dut_c (
      .clk(clk), .reset(rst_c), .en(en_c), .up(up_c), .load(ld_c), .load_val(lv_c),
      .q(q_c), .ovf(ovf_c), .unf(unf_c), .at_max(amax_c), .at_zero(azero_c));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour written directly from the counting rules with integer arithmetic.
   function automatic st_t ref_next(st_t s, longint unsigned maxv, longint unsigned step,
                                    bit sat, bit rst, bit ld, bit e, bit u,
                                    longint unsigned lv);
      st_t n;
      n.q   = s.q;
      n.ovf = 1'b0;
      n.unf = 1'b0;
      if (rst) begin
         n.q = 0;
      end else if (ld) begin
         n.q = (lv > maxv) ? maxv : lv;
      end else if (e && u) begin
         if (s.q + step > maxv) begin
            n.ovf = 1'b1;
            n.q   = sat ? maxv : s.q + step - (maxv + 1);
         end else begin
            n.q = s.q + step;
         end
      end else if (e) begin
         if (step > s.q) begin
            n.unf = 1'b1;
            n.q   = sat ? 0 : s.q + (maxv + 1) - step;
         end else begin
            n.q = s.q - step;
         end
      end
      return n;
   endfunction

   task automatic cmp_dut(input string nm, input logic [63:0] q, input logic ov, input logic un,
                          input logic amx, input logic azr, input st_t s,
                          input longint unsigned maxv);
      check({nm, ".q"},       q,       s.q);
      check({nm, ".ovf"},     64'(ov), 64'(s.ovf));
      check({nm, ".unf"},     64'(un), 64'(s.unf));
      check({nm, ".at_max"},  64'(amx), 64'(s.q == maxv));
      check({nm, ".at_zero"}, 64'(azr), 64'(s.q == 0));
   endtask

   // One clock: advance the models with the current inputs, then compare all instances.
   task automatic tick();
      sa = ref_next(sa, 9, 1, 1'b0, rst_a, ld_a, en_a, up_a, 64'(lv_a));
      sb = ref_next(sb, 9, 3, 1'b1, rst_b, ld_b, en_b, up_b, 64'(lv_b));
      sc = ref_next(sc, 64'hFFFF_FFFF, 1, 1'b0, rst_c, ld_c, en_c, up_c, 64'(lv_c));
      @(posedge clk);
      #1;
      cmp_dut("a", 64'(q_a), ovf_a, unf_a, amax_a, azero_a, sa, 9);
      cmp_dut("b", 64'(q_b), ovf_b, unf_b, amax_b, azero_b, sb, 9);
      cmp_dut("c", 64'(q_c), ovf_c, unf_c, amax_c, azero_c, sc, 64'hFFFF_FFFF);
   endtask

   task automatic idle_all();
      rst_a = 0; en_a = 0; up_a = 0; ld_a = 0; lv_a = '0;
      rst_b = 0; en_b = 0; up_b = 0; ld_b = 0; lv_b = '0;
      rst_c = 0; en_c = 0; up_c = 0; ld_c = 0; lv_c = '0;
   endtask

   initial begin
      int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int exp3 [4]  = '{6, 3, 0, 0};
      sa = '{q: 0, ovf: 0, unf: 0};
      sb = sa;
      sc = sa;
      idle_all();
      rst_a = 1; rst_b = 1; rst_c = 1;
      tick();
      check("reset.q_a", 64'(q_a), 0);
      check("reset.zero_a", 64'(azero_a), 1);
      idle_all();

      // Wrap counting up through the terminal value
      en_a = 1; up_a = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("t1.q[%0d]", i), 64'(q_a), 64'(exp1[i]));
         check($sformatf("t1.ovf[%0d]", i), 64'(ovf_a), 64'(i == 9));
      end

      // Wrap counting down through zero
      idle_all(); ld_a = 1; lv_a = 4'd0;
      tick();
      idle_all(); en_a = 1; up_a = 0;
      tick();
      check("t2.q0", 64'(q_a), 9);
      check("t2.unf0", 64'(unf_a), 1);
      tick();
      check("t2.q1", 64'(q_a), 8);
      check("t2.unf1", 64'(unf_a), 0);

      // Saturating step of 3 held at both limits
      idle_all(); ld_b = 1; lv_b = 4'd8;
      tick();
      idle_all(); en_b = 1; up_b = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t3.up.q[%0d]", i), 64'(q_b), 9);
         check($sformatf("t3.up.ovf[%0d]", i), 64'(ovf_b), 1);
      end
      up_b = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t3.dn.q[%0d]", i), 64'(q_b), 64'(exp3[i]));
         check($sformatf("t3.dn.unf[%0d]", i), 64'(unf_b), 64'(i == 3));
      end

      // Load clamping and load-over-enable priority
      idle_all(); ld_a = 1; lv_a = 4'd12;
      tick();
      check("t4.clamp", 64'(q_a), 9);
      check("t4.clamp_max", 64'(amax_a), 1);
      en_a = 1; up_a = 1; lv_a = 4'd4;
      tick();
      check("t4.ld_en.q", 64'(q_a), 4);
      check("t4.ld_en.ovf", 64'(ovf_a), 0);

      // Reset overrides load and enable mid-count
      idle_all(); ld_a = 1; lv_a = 4'd5;
      tick();
      rst_a = 1; ld_a = 1; en_a = 1; up_a = 1; lv_a = 4'd7;
      tick();
      check("t5.q", 64'(q_a), 0);
      check("t5.zero", 64'(azero_a), 1);
      check("t5.ovf", 64'(ovf_a), 0);

      // Full-range default instance: carry-out at all-ones
      idle_all(); ld_c = 1; lv_c = 32'hFFFF_FFFF;
      tick();
      check("t6.max_before", 64'(amax_c), 1);
      idle_all(); en_c = 1; up_c = 1;
      tick();
      check("t6.q", 64'(q_c), 0);
      check("t6.ovf", 64'(ovf_c), 1);
      check("t6.zero_after", 64'(azero_c), 1);
      idle_all();
      tick();
      check("t6.ovf_pulse_end", 64'(ovf_c), 0);

      // Randomised traffic on all instances
      for (int n = 0; n < 400; n++) begin
         rst_a = ($urandom_range(0, 40) == 0);
         rst_b = ($urandom_range(0, 40) == 0);
         rst_c = ($urandom_range(0, 40) == 0);
         ld_a = ($urandom_range(0, 7) == 0); en_a = $urandom_range(0, 3) != 0;
         ld_b = ($urandom_range(0, 7) == 0); en_b = $urandom_range(0, 3) != 0;
         ld_c = ($urandom_range(0, 7) == 0); en_c = $urandom_range(0, 3) != 0;
         up_a = 1'($urandom); up_b = 1'($urandom); up_c = 1'($urandom);
         lv_a = 4'($urandom); lv_b = 4'($urandom);
         lv_c = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                            : 32'($urandom_range(0, 3));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
